apb_master_bridge: RTL and testbench
====================================

// Module: apb_master_bridge
// PURPOSE
// - APB (AMBA APB4) requester: turns one command from a simple valid/ready command port into one APB transfer.
// - Returns the result on a valid/ready response port.
// - Drives the byte-serial APB slave devices on the peripheral bus; those devices may hold p_ready low for several ACCESS cycles.
// - One outstanding transfer at a time; no pipelining across transfers.
// PARAMETERS
// - AddrBits   32  width of cmd_addr / p_addr
// - TimeoutCyc 16  ACCESS-phase cycle limit; used only with APB_MASTER_TIMEOUT_EN; legal range >= 1
// PORTS
// - p_clk       in   1         bus clock; all logic on rising edge
// - p_reset     in   1         synchronous, active-high reset
// - cmd_valid   in   1         command offered
// - cmd_ready   out  1         command accepted when cmd_valid & cmd_ready at clock edge
// - cmd_write   in   1         1 = write, 0 = read
// - cmd_addr    in   AddrBits  transfer address
// - cmd_wdata   in   32        write data
// - cmd_strb    in   4         write byte strobes (ignored for reads)
// - rsp_valid   out  1         response available
// - rsp_ready   in   1         response consumed when rsp_valid & rsp_ready
// - rsp_rdata   out  32        read data (0 for writes)
// - rsp_slverr  out  1         transfer error (p_slverr, or timeout)
// - p_addr      out  AddrBits  APB address
// - p_sel       out  1         APB select
// - p_enable    out  1         APB enable
// - p_write     out  1         APB direction
// - p_wdata     out  32        APB write data
// - p_strb      out  4         APB strobes
// - p_rdata     in   32        APB read data
// - p_ready     in   1         APB ready
// - p_slverr    in   1         APB error, sampled only with p_ready
// BEHAVIOUR
// - FSM states: IDLE -> SETUP -> ACCESS -> RESP -> IDLE. All outputs registered except cmd_ready = (state==IDLE).
// - Reset (p_reset=1 at edge, any state): state=IDLE.
//   - Zeroed: p_sel, p_enable, p_write, p_addr, p_wdata, p_strb, rsp_valid, rsp_rdata, rsp_slverr.
//   - An in-flight transfer is abandoned with no response; p_sel drops on the next cycle.
// - IDLE: on cmd accept, latch the command into p_addr/p_write/p_wdata/p_strb.
//   - p_strb = cmd_write ? cmd_strb : 4'b0000; p_wdata = cmd_write ? cmd_wdata : 0.
//   - Set p_sel=1, p_enable=0 -> SETUP.
// - SETUP: exactly one cycle. Next edge sets p_enable=1 -> ACCESS.
// - ACCESS: p_addr/p_write/p_wdata/p_strb/p_sel held stable while p_ready=0 (wait states unbounded unless timeout enabled).
//   - On p_ready=1: capture rsp_rdata = p_write ? 0 : p_rdata and rsp_slverr = p_slverr.
//   - Same edge: p_sel=0, p_enable=0, rsp_valid=1 -> RESP.
// - RESP: rsp_valid held with stable data until rsp_ready=1. Then rsp_valid=0 -> IDLE.
//   - cmd_ready rises the cycle after the response handshake; minimum command-to-command spacing = 4 cycles.
// - p_slverr or p_rdata while p_ready=0: ignored.
// - cmd_valid while not IDLE: ignored (not accepted); command inputs sampled only on the accepting edge.
// - Write with cmd_strb=4'b0000: issued as-is on APB; completes on p_ready like any write.
// CONFIGURATION
// - APB_MASTER_TIMEOUT_EN defined:
//   - Counter (clog2(TimeoutCyc+1) bits) clears on entering ACCESS and increments each ACCESS cycle with p_ready=0.
//   - When it reaches TimeoutCyc with p_ready still 0: abort.
//   - Abort: p_sel=0, p_enable=0, rsp_slverr=1, rsp_rdata=0 -> RESP.
//   - p_ready=1 on the same cycle as the limit wins (normal completion).
// - APB_MASTER_TIMEOUT_EN undefined: no counter; ACCESS waits for p_ready indefinitely; TimeoutCyc unused.
// TESTING
// - Write: cmd addr=0x10, wdata=0xA5A5_A5A5, strb=4'b1111; slave p_ready on 4th ACCESS cycle.
//   -> Setup phase: p_sel=1, p_enable=0 for 1 cycle.
//   -> Access phase: 4 cycles with p_enable=1, p_strb=4'b1111.
//   -> rsp_valid=1, rsp_slverr=0, rsp_rdata=0.
// - Read: addr=0x20, slave p_ready in 1st ACCESS cycle with p_rdata=0x1234_5678.
//   -> p_strb=0000, rsp_rdata=0x1234_5678, total latency accept->rsp_valid = 3 edges.
// - Error: p_ready=1, p_slverr=1 -> rsp_slverr=1; p_slverr=1 while p_ready=0 -> no effect.
// - Backpressure: rsp_ready=0 for 5 cycles, then cmd_valid held -> rsp stable, cmd_ready=0.
//   -> 2nd command accepted only 1 cycle after the response handshake.
// - Reset mid-ACCESS (p_reset=1 for 1 cycle) -> next cycle p_sel=0, p_enable=0, rsp_valid=0, cmd_ready=1.
// - With APB_MASTER_TIMEOUT_EN, TimeoutCyc=3, slave never ready -> abort after 3 ACCESS cycles.
//   -> rsp_slverr=1, rsp_rdata=0.

Source files
------------

// File: rtl/apb_master_bridge.sv
// APB4 requester: one valid/ready command becomes one APB transfer, with the result returned on a valid/ready response port.
// Optional ACCESS-phase timeout abort is enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master_bridge #(
  parameter int AddrBits   = 32,
  parameter int TimeoutCyc = 16
) (
  input  logic                p_clk,
  input  logic                p_reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [AddrBits-1:0] cmd_addr,
  input  logic [31:0]         cmd_wdata,
  input  logic [3:0]          cmd_strb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [31:0]         rsp_rdata,
  output logic                rsp_slverr,
  output logic [AddrBits-1:0] p_addr,
  output logic                p_sel,
  output logic                p_enable,
  output logic                p_write,
  output logic [31:0]         p_wdata,
  output logic [3:0]          p_strb,
  input  logic [31:0]         p_rdata,
  input  logic                p_ready,
  input  logic                p_slverr
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t state;

  if (TimeoutCyc < 1) begin : g_bad_timeout
    $error("TimeoutCyc must be >= 1");
  end

  assign cmd_ready = (state == IDLE);

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CntBits = $clog2(TimeoutCyc + 1);

  logic [CntBits-1:0] to_cnt;
  logic               timeout_hit;

  // This wait cycle is the TimeoutCyc-th one without p_ready.
  assign timeout_hit = (to_cnt == CntBits'(TimeoutCyc - 1));
`endif

  always_ff @(posedge p_clk) begin
    if (p_reset) begin
      state      <= IDLE;
      p_sel      <= 1'b0;
      p_enable   <= 1'b0;
      p_write    <= 1'b0;
      p_addr     <= '0;
      p_wdata    <= '0;
      p_strb     <= '0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_slverr <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      to_cnt     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            p_addr   <= cmd_addr;
            p_write  <= cmd_write;
            p_wdata  <= cmd_write ? cmd_wdata : 32'h0;
            p_strb   <= cmd_write ? cmd_strb : 4'b0000;
            p_sel    <= 1'b1;
            p_enable <= 1'b0;
            state    <= SETUP;
          end
        end
        SETUP: begin
          p_enable <= 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
          to_cnt   <= '0;
`endif
          state    <= ACCESS;
        end
        ACCESS: begin
          // p_ready wins over a timeout landing on the same cycle.
          if (p_ready) begin
            rsp_rdata  <= p_write ? 32'h0 : p_rdata;
            rsp_slverr <= p_slverr;
            p_sel      <= 1'b0;
            p_enable   <= 1'b0;
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end
`ifdef APB_MASTER_TIMEOUT_EN
          else if (timeout_hit) begin
            rsp_rdata  <= 32'h0;
            rsp_slverr <= 1'b1;
            p_sel      <= 1'b0;
            p_enable   <= 1'b0;
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: directed table, hand sequences and random transfers against a transfer-level model.
module tb_apb_master_bridge;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int TO = 3;

  logic        p_clk = 1'b0;
  logic        p_reset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_strb;
  logic        rsp_valid, rsp_ready, rsp_slverr;
  logic [31:0] rsp_rdata;
  logic [31:0] p_addr, p_wdata, p_rdata;
  logic        p_sel, p_enable, p_write, p_ready, p_slverr;
  logic [3:0]  p_strb;

  int total = 0;
  int bad   = 0;

  apb_master_bridge #(.AddrBits(32), .TimeoutCyc(TO)) dut (
    .p_clk(p_clk), .p_reset(p_reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_slverr(rsp_slverr),
    .p_addr(p_addr), .p_sel(p_sel), .p_enable(p_enable), .p_write(p_write),
    .p_wdata(p_wdata), .p_strb(p_strb), .p_rdata(p_rdata), .p_ready(p_ready),
    .p_slverr(p_slverr)
  );

  always #5 p_clk = ~p_clk;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          waits;     // ACCESS cycles the slave holds p_ready low
    logic [31:0] prdata;
    bit          perr;
    int          rsp_dly;   // cycles of response backpressure
    logic [31:0] exp_rdata;
    bit          exp_err;
    int          exp_acc;   // ACCESS cycles seen on the bus
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Transfer-level reference: what a requester must report for a given slave behaviour.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    bit   timed_out = TO_EN && (v.waits >= TO);
    r.exp_acc   = timed_out ? TO : v.waits + 1;
    r.exp_err   = timed_out | v.perr;
    r.exp_rdata = (v.wr || timed_out) ? 32'h0 : v.prdata;
    return r;
  endfunction

  // Entered and left at a negedge with the DUT idle.
  task automatic run_xfer(input vec_t v, input string tag);
    int          n = 0;
    bit          done = 0;
    logic [31:0] hold_rdata;
    logic        hold_err;
    cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr;
    cmd_wdata = v.wdata; cmd_strb = v.strb;
    chk({tag, "_cmd_ready_idle"}, cmd_ready, 1);
    @(negedge p_clk);
    cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = $urandom;
    cmd_wdata = $urandom; cmd_strb = 4'($urandom);
    chk({tag, "_setup_sel"}, p_sel, 1);
    chk({tag, "_setup_en"}, p_enable, 0);
    chk({tag, "_setup_cmd_ready"}, cmd_ready, 0);
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge p_clk);
      if (p_sel && p_enable) begin
        chk({tag, "_addr"}, p_addr, v.addr);
        chk({tag, "_write"}, p_write, v.wr);
        chk({tag, "_wdata"}, p_wdata, v.wr ? v.wdata : 32'h0);
        chk({tag, "_strb"}, p_strb, v.wr ? v.strb : 4'h0);
        if (n == v.waits) begin
          p_ready = 1'b1; p_rdata = v.prdata; p_slverr = v.perr;
        end else begin
          p_ready = 1'b0; p_rdata = $urandom; p_slverr = 1'b1;
        end
        n++;
      end else begin
        done = 1;
      end
    end
    chk({tag, "_bounded"}, done, 1);
    p_ready = 1'b0; p_slverr = 1'b0; p_rdata = $urandom;
    chk({tag, "_access_cycles"}, n, v.exp_acc);
    chk({tag, "_rsp_valid"}, rsp_valid, 1);
    chk({tag, "_rsp_rdata"}, rsp_rdata, v.exp_rdata);
    chk({tag, "_rsp_slverr"}, rsp_slverr, v.exp_err);
    chk({tag, "_resp_sel"}, p_sel, 0);
    chk({tag, "_resp_en"}, p_enable, 0);
    hold_rdata = v.exp_rdata;
    hold_err   = v.exp_err;
    cmd_valid = 1'b1;
    for (int k = 0; k < v.rsp_dly; k++) begin
      @(negedge p_clk);
      chk({tag, "_bp_valid"}, rsp_valid, 1);
      chk({tag, "_bp_rdata"}, rsp_rdata, hold_rdata);
      chk({tag, "_bp_err"}, rsp_slverr, hold_err);
      chk({tag, "_bp_cmd_ready"}, cmd_ready, 0);
      chk({tag, "_bp_sel"}, p_sel, 0);
    end
    rsp_ready = 1'b1;
    @(negedge p_clk);
    rsp_ready = 1'b0; cmd_valid = 1'b0;
    chk({tag, "_rsp_done"}, rsp_valid, 0);
    chk({tag, "_cmd_ready_after"}, cmd_ready, 1);
    chk({tag, "_idle_sel"}, p_sel, 0);
  endtask

  vec_t vecs[6];

  initial begin
    vec_t rv;
    vecs[0] = '{1'b1, 32'h10, 32'hA5A5_A5A5, 4'hF, 3, 32'hDEAD_BEEF, 1'b0, 0,
                32'h0, TO_EN, TO_EN ? 3 : 4};
    vecs[1] = '{1'b0, 32'h20, 32'hFFFF_FFFF, 4'hF, 0, 32'h1234_5678, 1'b0, 0,
                32'h1234_5678, 1'b0, 1};
    vecs[2] = '{1'b0, 32'h24, 32'h0, 4'h0, 2, 32'hCAFE_F00D, 1'b1, 1,
                32'hCAFE_F00D, 1'b1, 3};
    vecs[3] = '{1'b1, 32'h30, 32'h0000_55AA, 4'h0, 1, 32'h7777_7777, 1'b0, 5,
                32'h0, 1'b0, 2};
    vecs[4] = '{1'b1, 32'h34, 32'h0BAD_CAFE, 4'h5, 0, 32'h0, 1'b1, 0,
                32'h0, 1'b1, 1};
    vecs[5] = '{1'b0, 32'h40, 32'h0, 4'h0, 10, 32'h1111_2222, 1'b0, 2,
                TO_EN ? 32'h0 : 32'h1111_2222, TO_EN, TO_EN ? 3 : 11};

    p_reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_strb = '0; rsp_ready = 1'b0;
    p_rdata = '0; p_ready = 1'b0; p_slverr = 1'b0;
    repeat (3) @(negedge p_clk);
    p_reset = 1'b0;
    chk("rst_sel", p_sel, 0);
    chk("rst_en", p_enable, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_addr", p_addr, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_strb", p_strb, 0);

    for (int i = 0; i < 6; i++) run_xfer(vecs[i], $sformatf("vec%0d", i));

    // Reset while the slave is stalling in ACCESS.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h50;
    cmd_wdata = 32'h1357_9BDF; cmd_strb = 4'hF;
    @(negedge p_clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge p_clk);
    chk("mid_access_en", p_enable, 1);
    p_reset = 1'b1;
    @(negedge p_clk);
    p_reset = 1'b0;
    chk("mid_rst_sel", p_sel, 0);
    chk("mid_rst_en", p_enable, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_cmd_ready", cmd_ready, 1);
    repeat (3) @(negedge p_clk);
    chk("mid_rst_no_rsp", rsp_valid, 0);
    run_xfer(vecs[1], "post_rst");

    for (int i = 0; i < 40; i++) begin
      rv.wr      = 1'($urandom_range(0, 1));
      rv.addr    = $urandom;
      rv.wdata   = $urandom;
      rv.strb    = 4'($urandom);
      rv.waits   = $urandom_range(0, 5);
      rv.prdata  = $urandom;
      rv.perr    = ($urandom_range(0, 3) == 0);
      rv.rsp_dly = $urandom_range(0, 2);
      run_xfer(model(rv), $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
